// File: rtl/seq_alu_if.sv
// Bus bundle for the sequential ALU: operands/function select in, handshake and
// registered result/status out.
interface seq_alu_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [4:0]       FS;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] F;
   logic [3:0]       status;

   // Requester side (control unit / bench).
   modport master (
      output start, FS, A, B,
      input  busy, done, F, status
   );

   // ALU side.
   modport slave (
      input  start, FS, A, B,
      output busy, done, F, status
   );
endinterface

// File: rtl/seq_alu.sv
// Registered execute-stage ALU. Logic/add/shift ops complete in one clock;
// unsigned multiply runs as a WIDTH-step shift-add on latched operands.
// Status is {V, C, Z, N}; F/status only change on a done pulse.
module seq_alu #(
   parameter int WIDTH = 64,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic         clock,
   input  logic         reset,
   seq_alu_if.slave     bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SHL = 3'b100;
   localparam logic [2:0] OP_SHR = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   f_q, f_d;
   logic [3:0]         status_q, status_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]     cnt_q, cnt_d;

   logic [WIDTH-1:0]   ac_s, bc_s;
   logic [WIDTH:0]     sum_s;
   logic               add_v_s;
   logic [WIDTH-1:0]   one_f_s;
   logic               one_v_s, one_c_s;
   logic [3:0]         one_st_s;
   logic [2*WIDTH-1:0] acc_next_s;
   logic [3:0]         mul_st_s;

   // Single-cycle datapath: conditioned operands, adder, op mux and status.
   always_comb begin
      ac_s    = bus.FS[1] ? ~bus.A : bus.A;
      bc_s    = bus.FS[0] ? ~bus.B : bus.B;
      sum_s   = {1'b0, ac_s} + {1'b0, bc_s} + {{WIDTH{1'b0}}, bus.FS[0]};
      add_v_s = ~(ac_s[WIDTH-1] ^ bc_s[WIDTH-1]) & (ac_s[WIDTH-1] ^ sum_s[WIDTH-1]);
      one_f_s = {WIDTH{1'b0}};
      one_v_s = 1'b0;
      one_c_s = 1'b0;
      case (bus.FS[4:2])
         OP_AND:  one_f_s = ac_s & bc_s;
         OP_OR:   one_f_s = ac_s | bc_s;
         OP_ADD: begin
            one_f_s = sum_s[WIDTH-1:0];
            one_c_s = sum_s[WIDTH];
            one_v_s = add_v_s;
         end
         OP_XOR:  one_f_s = ac_s ^ bc_s;
         // Shifts deliberately use the raw operands, ignoring the invert bits.
         OP_SHL:  one_f_s = bus.A << bus.B[SHW-1:0];
         OP_SHR:  one_f_s = bus.A >> bus.B[SHW-1:0];
         default: one_f_s = {WIDTH{1'b0}};
      endcase
      one_st_s = {one_v_s, one_c_s, (one_f_s == {WIDTH{1'b0}}), one_f_s[WIDTH-1]};
   end

   // One shift-add step and the status the multiply would report if this is the last step.
   always_comb begin
      acc_next_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
      mul_st_s   = {(acc_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}), 1'b0,
                    (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}}), acc_next_s[WIDTH-1]};
   end

   // Control FSM: accept starts in IDLE, iterate the multiply, publish results.
   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      f_d      = f_q;
      status_d = status_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.FS[4:2] == OP_MUL) begin
                  mcand_d  = {{WIDTH{1'b0}}, ac_s};
                  mplier_d = bc_s;
                  acc_d    = {(2*WIDTH){1'b0}};
                  cnt_d    = {SHW{1'b0}};
                  state_d  = ST_MUL;
               end else begin
                  f_d      = one_f_s;
                  status_d = one_st_s;
                  done_d   = 1'b1;
                  state_d  = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            // New starts are ignored here; operands come only from the latched copies.
            acc_d    = acc_next_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH - 1)) begin
               f_d      = acc_next_s[WIDTH-1:0];
               status_d = mul_st_s;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d  = ST_MUL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_MUL);
   end

   // State and output registers; reset aborts any multiply in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         f_q      <= {WIDTH{1'b0}};
         status_q <= 4'b0000;
         mcand_q  <= {(2*WIDTH){1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         acc_q    <= {(2*WIDTH){1'b0}};
         cnt_q    <= {SHW{1'b0}};
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         f_q      <= f_d;
         status_q <= status_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.F      = f_q;
   assign bus.status = status_q;

endmodule
